// File: rtl/ski_reduce_engine.sv
// rtl/ski_reduce_engine.sv - sequential SKI graph reducer to weak head normal form
module ski_reduce_engine #(
    parameter int PTR_W       = 16,
    parameter int STACK_DEPTH = 32,
    parameter int STEP_W      = 32
) (
    input  logic                   system1000,
    input  logic                   system1000_rst,
    input  logic                   start_i,
    input  logic [PTR_W-1:0]       root_i,
    input  logic [PTR_W-1:0]       heap_free_i,
    input  logic [PTR_W-1:0]       heap_limit_i,
    input  logic [STEP_W-1:0]      max_steps_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [PTR_W-1:0]       mem_addr_o,
    output logic [2+2*PTR_W-1:0]   mem_wdata_o,
    input  logic                   mem_ack_i,
    input  logic [2+2*PTR_W-1:0]   mem_rdata_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2:0]             status_o,
    output logic [PTR_W-1:0]       result_o,
    output logic [STEP_W-1:0]      steps_o
);

    localparam int NODE_W = 2 + 2 * PTR_W;
    localparam int SP_RAW = $clog2(STACK_DEPTH + 1);
    localparam int SP_W   = (SP_RAW < 2) ? 2 : SP_RAW;
    localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] C_S = 2'd0;
    localparam logic [1:0] C_K = 2'd1;
    localparam logic [1:0] C_I = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    cur_q, cur_d, free_q, free_d, limit_q, limit_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [STEP_W-1:0]   steps_q, steps_d, max_q, max_d, steps_out_q, steps_out_d;
    logic [NODE_W-1:0]   node_q, node_d;
    logic [1:0]          code_q, code_d, widx_q, widx_d;
    logic [2:0]          status_q, status_d;
    logic [PTR_W-1:0]    result_q, result_d;
    logic [2*PTR_W-1:0]  stack_q [STACK_DEPTH];
    logic                push_en;

    function automatic logic [1:0] nargs_f(input logic [1:0] c);
        case (c)
            C_S:     nargs_f = 2'd3;
            C_K:     nargs_f = 2'd2;
            default: nargs_f = 2'd1;
        endcase
    endfunction

    function automatic logic [NODE_W-1:0] ind_w(input logic [PTR_W-1:0] t);
        ind_w = {2'b10, {PTR_W{1'b0}}, t};
    endfunction

    logic [1:0]       tag, n_code;
    logic [PTR_W-1:0] n_left, n_right;
    assign tag     = node_q[NODE_W-1 -: 2];
    assign n_left  = node_q[2*PTR_W-1:PTR_W];
    assign n_right = node_q[PTR_W-1:0];
    assign n_code  = node_q[1:0];

    // a_k is the application node k levels up the spine, x_k its argument
    logic [IDX_W-1:0]   idx1, idx2, idx3;
    logic [2*PTR_W-1:0] e1, e2, e3;
    logic [PTR_W-1:0]   a1, a2, a3, x1, x2, x3, free_p1;
    assign idx1    = IDX_W'(sp_q - SP_W'(1));
    assign idx2    = IDX_W'(sp_q - SP_W'(2));
    assign idx3    = IDX_W'(sp_q - SP_W'(3));
    assign e1      = stack_q[idx1];
    assign e2      = stack_q[idx2];
    assign e3      = stack_q[idx3];
    assign a1      = e1[2*PTR_W-1:PTR_W];
    assign x1      = e1[PTR_W-1:0];
    assign a2      = e2[2*PTR_W-1:PTR_W];
    assign x2      = e2[PTR_W-1:0];
    assign a3      = e3[2*PTR_W-1:PTR_W];
    assign x3      = e3[PTR_W-1:0];
    assign free_p1 = free_q + PTR_W'(1);

    logic             heap_short;
    assign heap_short = ({1'b0, free_q} + (PTR_W+1)'(2)) > {1'b0, limit_q};

    logic             fin, last;
    logic [2:0]       fin_status;
    logic [PTR_W-1:0] fin_result;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        free_d      = free_q;
        limit_d     = limit_q;
        sp_d        = sp_q;
        steps_d     = steps_q;
        max_d       = max_q;
        steps_out_d = steps_out_q;
        node_d      = node_q;
        code_d      = code_q;
        widx_d      = widx_q;
        status_d    = status_q;
        result_d    = result_q;
        push_en     = 1'b0;
        fin         = 1'b0;
        fin_status  = 3'd0;
        fin_result  = cur_q;
        last        = 1'b1;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = cur_q;
        mem_wdata_o = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cur_d   = root_i;
                    free_d  = heap_free_i;
                    limit_d = heap_limit_i;
                    max_d   = max_steps_i;
                    sp_d    = '0;
                    steps_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    node_d  = mem_rdata_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (tag)
                    2'b00: begin
                        if (sp_q == SP_W'(STACK_DEPTH)) begin
                            fin        = 1'b1;
                            fin_status = 3'd2;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SP_W'(1);
                            cur_d   = n_left;
                            state_d = S_FETCH;
                        end
                    end
                    2'b10: begin
                        cur_d   = n_right;
                        state_d = S_FETCH;
                    end
                    2'b01: begin
                        fin = 1'b1;
                        if (n_code == 2'd3) begin
                            fin_status = 3'd4;
                        end else if (SP_W'(nargs_f(n_code)) > sp_q) begin
                            fin_status = 3'd0;
                            fin_result = (sp_q != '0) ? stack_q[0][2*PTR_W-1:PTR_W] : cur_q;
                        end else if (max_q != '0 && steps_q == max_q) begin
                            fin_status = 3'd1;
                        end else if (n_code == C_S && heap_short) begin
                            fin_status = 3'd3;
                        end else begin
                            fin     = 1'b0;
                            code_d  = n_code;
                            widx_d  = 2'd0;
                            state_d = S_WRITE;
                        end
                    end
                    default: begin
                        fin        = 1'b1;
                        fin_status = 3'd4;
                    end
                endcase
            end
            S_WRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                case (code_q)
                    C_I: begin
                        mem_addr_o  = a1;
                        mem_wdata_o = ind_w(x1);
                    end
                    C_K: begin
                        mem_addr_o  = a2;
                        mem_wdata_o = ind_w(x1);
                    end
                    default: begin
                        // S builds both fresh apps before overwriting its redex root
                        case (widx_q)
                            2'd0: begin
                                last        = 1'b0;
                                mem_addr_o  = free_q;
                                mem_wdata_o = {2'b00, x1, x3};
                            end
                            2'd1: begin
                                last        = 1'b0;
                                mem_addr_o  = free_p1;
                                mem_wdata_o = {2'b00, x2, x3};
                            end
                            default: begin
                                mem_addr_o  = a3;
                                mem_wdata_o = {2'b00, free_q, free_p1};
                            end
                        endcase
                    end
                endcase
                if (mem_ack_i) begin
                    if (last) begin
                        sp_d    = sp_q - SP_W'(nargs_f(code_q));
                        cur_d   = (code_q == C_S) ? a3 : x1;
                        free_d  = (code_q == C_S) ? free_q + PTR_W'(2) : free_q;
                        steps_d = (&steps_q) ? steps_q : steps_q + STEP_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        widx_d = widx_q + 2'd1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (fin) begin
            status_d    = fin_status;
            result_d    = fin_result;
            steps_out_d = steps_q;
            state_d     = S_DONE;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            free_q      <= '0;
            limit_q     <= '0;
            sp_q        <= '0;
            steps_q     <= '0;
            max_q       <= '0;
            steps_out_q <= '0;
            node_q      <= '0;
            code_q      <= '0;
            widx_q      <= '0;
            status_q    <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            free_q      <= free_d;
            limit_q     <= limit_d;
            sp_q        <= sp_d;
            steps_q     <= steps_d;
            max_q       <= max_d;
            steps_out_q <= steps_out_d;
            node_q      <= node_d;
            code_q      <= code_d;
            widx_q      <= widx_d;
            status_q    <= status_d;
            result_q    <= result_d;
        end
    end

    always_ff @(posedge system1000) begin
        if (push_en) begin
            stack_q[IDX_W'(sp_q)] <= {cur_q, n_right};
        end
    end

    assign busy_o   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_WRITE);
    assign done_o   = (state_q == S_DONE);
    assign status_o = status_q;
    assign result_o = result_q;
    assign steps_o  = steps_out_q;

endmodule

// File: doc/ski_reduce_engine.md
Name: ski_reduce_engine

Overview:
- Parametrised, sequential successor to the single-step combinational SKI reducer.
- Performs complete graph reduction of an SKI term to weak head normal form (WHNF).
- Keeps an internal spine stack and drives an external heap memory through a req/ack handshake.
- Sits between the term loader and the result readback path; one reduction job at a time.

Parameters:
PTR_W, 16, heap pointer width; node word NODE_W = 2 + 2*PTR_W.
STACK_DEPTH, 32, spine stack entries; each entry holds {app_ptr, right_arg}.
STEP_W, 32, width of the reduction step counter and budget.

Ports:
system1000  in  1  clock.
system1000_rst  in  1  reset; synchronous, active-high.
start_i  in  1  begin a job; sampled only in IDLE.
root_i  in  PTR_W  term root pointer, latched on start.
heap_free_i  in  PTR_W  first free heap address, latched on start.
heap_limit_i  in  PTR_W  exclusive upper bound for allocation, latched on start.
max_steps_i  in  STEP_W  reduction budget; 0 means unlimited; latched on start.
mem_req_o  out  1  heap request.
mem_we_o  out  1  1 = write, 0 = read.
mem_addr_o  out  PTR_W  heap address.
mem_wdata_o  out  NODE_W  write data.
mem_ack_i  in  1  completes the current request.
mem_rdata_i  in  NODE_W  read data; valid in the ack cycle.
busy_o  out  1  high from the cycle after start until done.
done_o  out  1  one-cycle completion pulse.
status_o  out  3  completion status; held until the next start.
result_o  out  PTR_W  WHNF root pointer; held until the next start.
steps_o  out  STEP_W  number of reductions performed; held until the next start.

Behaviour:
- Node encoding:
  - tag [NODE_W-1:NODE_W-2].
  - 00 App: left = [2*PTR_W-1:PTR_W], right = [PTR_W-1:0].
  - 01 Comb: code [1:0]; 0 = S, 1 = K, 2 = I, 3 = invalid.
  - 10 Ind: target = [PTR_W-1:0].
  - 11 invalid.
- Reset values: mem_req_o=0, mem_we_o=0, busy_o=0, done_o=0, status_o=0, result_o=0, steps_o=0. State goes to IDLE, stack count 0.
- Reset while a memory request is outstanding abandons it; mem_req_o is 0 after the reset edge.
- Handshake:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable while mem_req_o=1 and mem_ack_i=0.
  - A transfer completes in the cycle where mem_req_o and mem_ack_i are both high.
  - A new request may be issued in the next cycle.
  - mem_ack_i while mem_req_o=0 is ignored.
- States: IDLE, FETCH, DECODE, WRITE, DONE.
- IDLE:
  - On start_i: latch inputs, set current=root_i, sp=0, steps=0; go to FETCH.
  - start_i while busy is ignored.
- FETCH: read current, then go to DECODE.
- DECODE:
  - App: if sp==STACK_DEPTH, status 2 (overflow). Otherwise push {current, right}, current=left, go to FETCH.
  - Ind: current=target, no push, no step counted; go to FETCH.
  - Comb with required args (S 3, K 2, I 1) greater than sp: WHNF, status 0.
    - result = app_ptr of stack[0] if sp>0, else current.
  - Comb invalid, or tag 11: status 4.
  - Budget: if max_steps_i != 0 and steps == max_steps_i before a reduction would start, status 1; result = current.
- Reductions (a1 = top of stack, a2 below it, etc.; xk = right arg of ak):
  - I: write a1 := Ind(x1); pop 1; current = x1.
  - K: write a2 := Ind(x1); pop 2; current = x1.
  - S:
    - Checked first: if free+2 > limit, status 3 with no writes.
    - Write free := App(x1,x3), then free+1 := App(x2,x3), then a3 := App(free, free+1), in that order.
    - free += 2; pop 3; current = a3.
- Each reduction increments steps by 1 after its final write is acked.
- Overflow: steps saturates at all-ones.
- DONE:
  - done_o=1 for one cycle; status_o, result_o and steps_o update in the same cycle.
  - busy_o drops with done_o.
  - Next state is IDLE.
- Status codes: 0 WHNF, 1 budget exhausted, 2 stack overflow, 3 heap exhausted, 4 bad node.

Test Plan:
- Heap node0=App(1,2), node1=I, node2=K; start root 0, mem_ack_i zero-wait -> done, status 0, result 2, steps 1; node0 reads Ind(2).
- node0=App(1,4), node1=App(2,3), node2=K, node3=S, node4=I -> status 0, result 3, steps 1; node0 = Ind(3).
- S K K I term, heap_free_i=8, heap_limit_i=16 -> writes to addresses 8 and 9 in order, status 0, result points to the I node, steps 2. Repeat with max_steps_i=1 -> status 1, steps 1.
- STACK_DEPTH=4, left-deep chain of 5 App nodes -> status 2. Same S K K I term with heap_limit_i=9 -> status 3, no writes.
- mem_ack_i delayed 3 cycles on every access -> address, data and control stable while waiting; same result as zero-wait. Reset asserted during a FETCH wait -> mem_req_o=0 and busy_o=0 next cycle, and a new start runs correctly.
- Node with tag 11 at root -> status 4, steps 0. start_i pulsed while busy -> ignored, job result unchanged.
